// File: rtl/vga_image_scanout_if.sv
// Bundles the image-ROM side and VGA side of the scanout block.
// The master modport is the scanout engine; the slave side is the ROM plus display.
interface vga_image_scanout_if;
  logic [1:0] img_sel;
  logic [2:0] pixel;
  logic [7:0] xoff;
  logic [7:0] yoff;
  logic [1:0] memorySelect;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       frame_start;

  modport master (
    input  img_sel, pixel,
    output xoff, yoff, memorySelect,
    output vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    output img_sel, pixel,
    input  xoff, yoff, memorySelect,
    input  vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_image_scanout.sv
// VGA scanout for a 256x256 3-bit image held in an external ROM.
// Stage 0: raster counters. Stage 1: ROM address plus delayed timing flags
// (ROM answers combinationally in this cycle). Stage 2: grayscale RGB and syncs.
module vga_image_scanout #(
  parameter int         H_ACTIVE    = 640,
  parameter int         H_FP        = 16,
  parameter int         H_SYNC      = 96,
  parameter int         H_BP        = 48,
  parameter int         V_ACTIVE    = 480,
  parameter int         V_FP        = 10,
  parameter int         V_SYNC      = 2,
  parameter int         V_BP        = 33,
  parameter int         IMG_X0      = 192,
  parameter int         IMG_Y0      = 112,
  parameter logic [7:0] BORDER_GRAY = 8'h20
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_image_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit copies of the raster boundaries so every compare is width-matched
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] IMG_X_BEG  = 10'(IMG_X0);
  localparam logic [9:0] IMG_X_END  = 10'(IMG_X0 + 256);
  localparam logic [9:0] IMG_Y_BEG  = 10'(IMG_Y0);
  localparam logic [9:0] IMG_Y_END  = 10'(IMG_Y0 + 256);

  // stage 0: raster position
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  // frame-synchronous image select
  logic [1:0] mem_sel_q, mem_sel_d;
  // stage 1: ROM address and delayed flags
  logic [7:0] xoff_q, xoff_d;
  logic [7:0] yoff_q, yoff_d;
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;
  logic       act1_q, act1_d;
  logic       img1_q, img1_d;
  logic       fs1_q, fs1_d;
  // stage 2: display outputs
  logic       hs2_q, hs2_d;
  logic       vs2_q, vs2_d;
  logic       blank2_q, blank2_d;
  logic [7:0] gray2_q, gray2_d;
  logic       fs2_q, fs2_d;

  // raw decode helpers
  logic       frame_end_s;
  logic       active_s;
  logic       in_img_s;
  logic [9:0] x_rel_s;
  logic [9:0] y_rel_s;

  // next-state logic for counters, select and both pipeline stages
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    mem_sel_d = mem_sel_q;
    xoff_d    = 8'd0;
    yoff_d    = 8'd0;

    frame_end_s = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    active_s    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    in_img_s    = (h_cnt_q >= IMG_X_BEG) && (h_cnt_q < IMG_X_END) &&
                  (v_cnt_q >= IMG_Y_BEG) && (v_cnt_q < IMG_Y_END);
    x_rel_s     = h_cnt_q - IMG_X_BEG;
    y_rel_s     = v_cnt_q - IMG_Y_BEG;

    // raster advance: h wraps every line, v wraps on the last line
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // image select only moves at the very last counter state of a frame
    if (frame_end_s) begin
      mem_sel_d = bus.img_sel;
    end else begin
      mem_sel_d = mem_sel_q;
    end

    // ROM address: image line goes to xoff, pixel within the line to yoff
    if (in_img_s) begin
      xoff_d = y_rel_s[7:0];
      yoff_d = x_rel_s[7:0];
    end else begin
      xoff_d = 8'd0;
      yoff_d = 8'd0;
    end

    hs1_d  = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
    vs1_d  = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
    act1_d = active_s;
    img1_d = in_img_s;
    fs1_d  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    // gray expansion replicates the 3-bit sample across the byte
    if (act1_q && img1_q) begin
      gray2_d = {bus.pixel, bus.pixel, bus.pixel[2:1]};
    end else if (act1_q) begin
      gray2_d = BORDER_GRAY;
    end else begin
      gray2_d = 8'h00;
    end

    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    blank2_d = act1_q;
    fs2_d    = fs1_q;
  end

  // all state; syncs reset to their inactive (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      mem_sel_q <= 2'd2;
      xoff_q    <= 8'd0;
      yoff_q    <= 8'd0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      act1_q    <= 1'b0;
      img1_q    <= 1'b0;
      fs1_q     <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      blank2_q  <= 1'b0;
      gray2_q   <= 8'h00;
      fs2_q     <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mem_sel_q <= mem_sel_d;
      xoff_q    <= xoff_d;
      yoff_q    <= yoff_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      act1_q    <= act1_d;
      img1_q    <= img1_d;
      fs1_q     <= fs1_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      blank2_q  <= blank2_d;
      gray2_q   <= gray2_d;
      fs2_q     <= fs2_d;
    end
  end

  assign bus.xoff         = xoff_q;
  assign bus.yoff         = yoff_q;
  assign bus.memorySelect = mem_sel_q;
  assign bus.vga_hs       = hs2_q;
  assign bus.vga_vs       = vs2_q;
  assign bus.vga_blank_n  = blank2_q;
  assign bus.vga_r        = gray2_q;
  assign bus.vga_g        = gray2_q;
  assign bus.vga_b        = gray2_q;
  assign bus.frame_start  = fs2_q;

endmodule

// File: tb/tb_vga_image_scanout.sv
// Directed bench for vga_image_scanout. Horizontal timing and the window
// column use the real 640x480 values; the vertical raster is shortened
// (12 active lines, 18 total, image from line 4) so several frames fit
// in a short run. cyc counts rising edges since the last reset release,
// so during cycle k the counters hold position k and outputs show k-2.
module tb_vga_image_scanout;

  localparam int HT   = 800;
  localparam int VA   = 12;
  localparam int VT   = 18;
  localparam int FRM  = HT * VT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_chk  = 0;
  int   n_fail = 0;

  // per-window tallies for sync/blank accounting
  int   win_lo = 0;
  int   win_hi = 0;
  int   hs_lo_cnt, vs_lo_cnt, blank_cnt, fs_cnt;

  vga_image_scanout_if bus ();

  vga_image_scanout #(
    .V_ACTIVE (VA),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .IMG_Y0   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  // small ROM model: a few marked addresses, constant elsewhere
  function automatic logic [2:0] rom_model(input logic [7:0] x, input logic [7:0] y);
    if (x == 8'd0 && y == 8'd0)        return 3'b101;
    else if (x == 8'd7 && y == 8'd255) return 3'b111;
    else if (y == 8'd1)                return 3'b000;
    else                               return 3'b010;
  endfunction

  assign bus.pixel = rom_model(bus.xoff, bus.yoff);

  // edge counter since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // tally output levels inside the current window
  always @(negedge clk) begin
    if (rst_n && cyc >= win_lo && cyc < win_hi) begin
      if (!bus.vga_hs)     hs_lo_cnt++;
      if (!bus.vga_vs)     vs_lo_cnt++;
      if (bus.vga_blank_n) blank_cnt++;
      if (bus.frame_start) fs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc < k && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},    32'(bus.vga_hs),       32'd1);
    check({tag, "_vs"},    32'(bus.vga_vs),       32'd1);
    check({tag, "_blank"}, 32'(bus.vga_blank_n),  32'd0);
    check({tag, "_r"},     32'(bus.vga_r),        32'd0);
    check({tag, "_fs"},    32'(bus.frame_start),  32'd0);
    check({tag, "_msel"},  32'(bus.memorySelect), 32'd2);
    check({tag, "_xoff"},  32'(bus.xoff),         32'd0);
    check({tag, "_yoff"},  32'(bus.yoff),         32'd0);
  endtask

  task automatic clear_tallies();
    hs_lo_cnt = 0;
    vs_lo_cnt = 0;
    blank_cnt = 0;
    fs_cnt    = 0;
  endtask

  task automatic check_tallies(input string tag);
    check({tag, "_hs_low"},  32'(hs_lo_cnt), 32'(96 * VT));
    check({tag, "_vs_low"},  32'(vs_lo_cnt), 32'(2 * HT));
    check({tag, "_blank"},   32'(blank_cnt), 32'(640 * VA));
    check({tag, "_fs_once"}, 32'(fs_cnt),    32'd1);
  endtask

  initial begin
    bus.img_sel = 2'd0;
    clear_tallies();

    // power-on reset
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // first frame_start two edges after release, memorySelect still 2
    goto(1);  check("fs_c1", 32'(bus.frame_start), 32'd0);
    goto(2);  check("fs_c2", 32'(bus.frame_start), 32'd1);
              check("blank_c2", 32'(bus.vga_blank_n), 32'd1);
              check("msel_c2", 32'(bus.memorySelect), 32'd2);
    goto(3);  check("fs_c3", 32'(bus.frame_start), 32'd0);
    goto(10); bus.img_sel = 2'd3;

    // hsync edges on line 1
    goto(1457); check("hs_655", 32'(bus.vga_hs), 32'd1);
    goto(1458); check("hs_656", 32'(bus.vga_hs), 32'd0);
    goto(1553); check("hs_751", 32'(bus.vga_hs), 32'd0);
    goto(1554); check("hs_752", 32'(bus.vga_hs), 32'd1);

    // border and blanking
    goto(1702); check("rgb_border", 32'(bus.vga_r), 32'h20);
    goto(2302); check("rgb_hblank", 32'(bus.vga_r), 32'h00);
                check("blank_hblank", 32'(bus.vga_blank_n), 32'd0);

    // window origin: address one cycle later, color two cycles later
    goto(3393); check("addr_org_x", 32'(bus.xoff), 32'd0);
                check("addr_org_y", 32'(bus.yoff), 32'd0);
                check("rgb_left_edge", 32'(bus.vga_r), 32'h20);
    goto(3394); check("addr_nx_y", 32'(bus.yoff), 32'd1);
                check("rgb_org_r", 32'(bus.vga_r), 32'hB6);
                check("rgb_org_g", 32'(bus.vga_g), 32'hB6);
                check("rgb_org_b", 32'(bus.vga_b), 32'hB6);
    goto(3395); check("rgb_zero", 32'(bus.vga_r), 32'h00);

    // right edge of the window
    goto(9248); check("addr_447_x", 32'(bus.xoff), 32'd7);
                check("addr_447_y", 32'(bus.yoff), 32'd255);
    goto(9249); check("addr_448_x", 32'(bus.xoff), 32'd0);
                check("addr_448_y", 32'(bus.yoff), 32'd0);
                check("rgb_447", 32'(bus.vga_r), 32'hFF);
    goto(9250); check("rgb_448", 32'(bus.vga_r), 32'h20);

    // window row beyond active video still addresses but shows black
    goto(9793); check("addr_v12_x", 32'(bus.xoff), 32'd8);
    goto(9794); check("rgb_v12", 32'(bus.vga_r), 32'h00);
                check("blank_v12", 32'(bus.vga_blank_n), 32'd0);

    // vsync edges
    goto(11201); check("vs_13", 32'(bus.vga_vs), 32'd1);
    goto(11202); check("vs_14", 32'(bus.vga_vs), 32'd0);
    goto(12801); check("vs_15", 32'(bus.vga_vs), 32'd0);
    goto(12802); check("vs_16", 32'(bus.vga_vs), 32'd1);

    // select value 3 taken at the frame boundary
    goto(FRM - 1); check("msel_f1_end", 32'(bus.memorySelect), 32'd2);
    win_lo = FRM + 2;
    win_hi = 2 * FRM + 2;
    goto(FRM);     check("msel_f2_start", 32'(bus.memorySelect), 32'd3);
    bus.img_sel = 2'd0;

    goto(2 * FRM - 1); check("msel_f2_end", 32'(bus.memorySelect), 32'd3);
    goto(2 * FRM);     check("msel_f3_start", 32'(bus.memorySelect), 32'd0);
    goto(2 * FRM + 10);
    check_tallies("frame2");

    // mid-frame change 0->1 must wait for the boundary
    goto(2 * FRM + 8 * HT); bus.img_sel = 2'd1;
    goto(2 * FRM + 8 * HT + 5); check("msel_mid", 32'(bus.memorySelect), 32'd0);
    goto(3 * FRM - 1); check("msel_f3_end", 32'(bus.memorySelect), 32'd0);
    goto(3 * FRM);     check("msel_f4_start", 32'(bus.memorySelect), 32'd1);

    // reset at (300,8) of frame 4 clears without waiting for an edge
    goto(3 * FRM + 8 * HT + 300);
    check("pre_rst_x", 32'(bus.xoff), 32'd4);
    check("pre_rst_y", 32'(bus.yoff), 32'd107);
    check("pre_rst_blank", 32'(bus.vga_blank_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (5) @(negedge clk);
    check_reset_outputs("mid_hold");
    clear_tallies();
    win_lo = 2;
    win_hi = FRM + 2;
    rst_n  = 1'b1;

    goto(2); check("fs_after_rst", 32'(bus.frame_start), 32'd1);
    goto(FRM - 1); check("msel_rst_f1_end", 32'(bus.memorySelect), 32'd2);
    goto(FRM);     check("msel_rst_f2", 32'(bus.memorySelect), 32'd1);
    goto(FRM + 10);
    check_tallies("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
